// File: rtl/mem_access_arbiter.sv
// Arbiter for the shared instruction/data memory: host program load phase,
// then one access per cycle among host, CPU data port and CPU fetch port.
module mem_access_arbiter #(
  parameter int unsigned AW         = 9,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_done,
  output logic          host_gnt,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic          ignt,
  output logic          irvalid,
  output logic [DW-1:0] irdata,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic          dgnt,
  output logic          drvalid,
  output logic [DW-1:0] drdata,
  output logic          cpu_run,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata
);

  // Starvation counter is at least 2 bits wide and can hold STARVE_LIM.
  localparam int unsigned SW_RAW = $clog2(STARVE_LIM + 1);
  localparam int unsigned SW     = (SW_RAW > 2) ? SW_RAW : 2;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          fetch_first;
  logic          dstore, dload;
  logic          ipend, dpend;
  logic [AW-1:0] raddr_q, waddr_q;
  logic [DW-1:0] wdata_q, irdata_q, drdata_q;

  // State register, read-owner bits and hold registers for memory drive/return data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      starve_cnt <= '0;
      ipend      <= 1'b0;
      dpend      <= 1'b0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      irdata_q   <= '0;
      drdata_q   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      ipend      <= ignt;
      dpend      <= dload;
      raddr_q    <= mem_raddr;
      waddr_q    <= mem_waddr;
      wdata_q    <= mem_wdata;
      irdata_q   <= irdata;
      drdata_q   <= drdata;
    end
  end

  // Next state, grants and starvation counter update.
  always_comb begin
    state_nxt   = state;
    starve_nxt  = starve_cnt;
    host_gnt    = 1'b0;
    ignt        = 1'b0;
    dgnt        = 1'b0;
    fetch_first = (starve_cnt == SW'(STARVE_LIM));
    if (!reset) begin
      case (state)
        LOAD: begin
          host_gnt = host_req;
          if (host_done) state_nxt = RUN;
        end
        RUN: begin
          if (host_req) begin
            host_gnt = 1'b1;
          end else if (fetch_first) begin
            if (ireq)      ignt = 1'b1;
            else if (dreq) dgnt = 1'b1;
          end else begin
            if (dreq)      dgnt = 1'b1;
            else if (ireq) ignt = 1'b1;
          end
          if (!ireq || ignt)
            starve_nxt = '0;
          else if (starve_cnt != SW'(STARVE_LIM))
            starve_nxt = starve_cnt + SW'(1);
        end
        default: state_nxt = LOAD;
      endcase
    end
  end

  // Memory drive for the granted requester; addresses hold when idle.
  always_comb begin
    dstore    = dgnt & dwe;
    dload     = dgnt & ~dwe;
    mem_we    = host_gnt | dstore;
    mem_waddr = waddr_q;
    mem_wdata = wdata_q;
    mem_raddr = raddr_q;
    if (host_gnt) begin
      mem_waddr = host_addr;
      mem_wdata = host_wdata;
    end else if (dstore) begin
      mem_waddr = daddr;
      mem_wdata = dwdata;
    end
    if (ignt)       mem_raddr = iaddr;
    else if (dload) mem_raddr = daddr;
  end

  // Read return: route mem_rdata to the owner recorded last cycle, else hold.
  always_comb begin
    irvalid = ipend;
    drvalid = dpend;
    irdata  = ipend ? mem_rdata : irdata_q;
    drdata  = dpend ? mem_rdata : drdata_q;
    cpu_run = (state == RUN);
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural synchronous memory.
module tb_mem_access_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_req, host_done, host_gnt;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          ireq, ignt, irvalid;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] irdata;
  logic          dreq, dwe, dgnt, drvalid;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata, drdata;
  logic          cpu_run, mem_we;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] tb_mem [512];

  int passed = 0;
  int total  = 0;

  mem_access_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(3)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_done(host_done), .host_gnt(host_gnt),
    .ireq(ireq), .iaddr(iaddr), .ignt(ignt), .irvalid(irvalid), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dgnt(dgnt),
    .drvalid(drvalid), .drdata(drdata), .cpu_run(cpu_run),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: write commits at the edge, read data registered one cycle.
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_waddr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_raddr];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) tb_mem[i] = '0;
    tb_mem[1] = 32'h0000_0040;
    tb_mem[3] = 32'h0000_0033;
    tb_mem[5] = 32'h0000_0055;
    mem_rdata = '0;
    reset = 1'b1;
    host_req = 1'b0; host_addr = '0; host_wdata = '0; host_done = 1'b0;
    ireq = 1'b0; iaddr = '0;
    dreq = 1'b0; dwe = 1'b0; daddr = '0; dwdata = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_irvalid", 32'(irvalid), 32'd0);
    chk("rst_drvalid", 32'(drvalid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_irdata", irdata, 32'd0);

    // Host load with fetch request held: only host is served.
    host_req = 1'b1; host_addr = 9'd2; host_wdata = 32'h2005_0006;
    ireq = 1'b1; iaddr = 9'd1;
    #1;
    chk("load_host_gnt", 32'(host_gnt), 32'd1);
    chk("load_ignt", 32'(ignt), 32'd0);
    chk("load_cpu_run", 32'(cpu_run), 32'd0);
    chk("load_mem_we", 32'(mem_we), 32'd1);
    chk("load_mem_waddr", 32'(mem_waddr), 32'd2);
    chk("load_mem_wdata", mem_wdata, 32'h2005_0006);
    step();
    chk("load_committed", tb_mem[2], 32'h2005_0006);

    // host_done pulse: still LOAD this cycle.
    host_req = 1'b0; host_done = 1'b1;
    #1;
    chk("done_ignt", 32'(ignt), 32'd0);
    step();
    host_done = 1'b0;
    #1;
    chk("run_cpu_run", 32'(cpu_run), 32'd1);
    chk("run_ignt", 32'(ignt), 32'd1);
    chk("run_mem_raddr", 32'(mem_raddr), 32'd1);
    chk("run_mem_we", 32'(mem_we), 32'd0);
    step();
    ireq = 1'b0;
    #1;
    chk("fetch_irvalid", 32'(irvalid), 32'd1);
    chk("fetch_irdata", irdata, 32'h0000_0040);
    step();
    chk("fetch_irvalid_one", 32'(irvalid), 32'd0);

    // Fetch vs data load: data wins three cycles, then fetch.
    ireq = 1'b1; iaddr = 9'd3;
    dreq = 1'b1; dwe = 1'b0; daddr = 9'd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("starve_dgnt", 32'(dgnt), 32'd1);
      chk("starve_ignt", 32'(ignt), 32'd0);
      chk("starve_raddr", 32'(mem_raddr), 32'd5);
      if (c > 0) chk("starve_drdata", drdata, 32'h0000_0055);
      step();
    end
    #1;
    chk("starve_c4_ignt", 32'(ignt), 32'd1);
    chk("starve_c4_dgnt", 32'(dgnt), 32'd0);
    chk("starve_c4_raddr", 32'(mem_raddr), 32'd3);
    chk("starve_c4_drvalid", 32'(drvalid), 32'd1);
    step();
    #1;
    chk("starve_clr_dgnt", 32'(dgnt), 32'd1);
    chk("starve_c5_irvalid", 32'(irvalid), 32'd1);
    chk("starve_c5_irdata", irdata, 32'h0000_0033);
    chk("starve_c5_drvalid", 32'(drvalid), 32'd0);
    step();
    #1;
    chk("starve_c6_dgnt", 32'(dgnt), 32'd1);
    step();
    #1;
    chk("starve_c7_dgnt", 32'(dgnt), 32'd1);
    step();

    // Counter at limit, host still wins.
    host_req = 1'b1; host_addr = 9'd10; host_wdata = 32'h0000_1234;
    #1;
    chk("prio_host_gnt", 32'(host_gnt), 32'd1);
    chk("prio_ignt", 32'(ignt), 32'd0);
    chk("prio_dgnt", 32'(dgnt), 32'd0);
    chk("prio_mem_waddr", 32'(mem_waddr), 32'd10);
    step();
    host_req = 1'b0;
    #1;
    chk("after_host_ignt", 32'(ignt), 32'd1);
    chk("after_host_dgnt", 32'(dgnt), 32'd0);
    chk("after_host_irvalid", 32'(irvalid), 32'd0);
    chk("after_host_drvalid", 32'(drvalid), 32'd0);
    step();
    ireq = 1'b0; dreq = 1'b0;
    step();

    // Store then load to the same address.
    dreq = 1'b1; dwe = 1'b1; daddr = 9'd7; dwdata = 32'h0000_00AA;
    #1;
    chk("store_dgnt", 32'(dgnt), 32'd1);
    chk("store_mem_we", 32'(mem_we), 32'd1);
    chk("store_mem_waddr", 32'(mem_waddr), 32'd7);
    chk("store_mem_wdata", mem_wdata, 32'h0000_00AA);
    step();
    dwe = 1'b0;
    #1;
    chk("load_dgnt", 32'(dgnt), 32'd1);
    chk("store_no_drvalid", 32'(drvalid), 32'd0);
    chk("ld_mem_raddr", 32'(mem_raddr), 32'd7);
    chk("ld_mem_we", 32'(mem_we), 32'd0);
    step();
    dreq = 1'b0;
    #1;
    chk("ld_drvalid", 32'(drvalid), 32'd1);
    chk("ld_drdata", drdata, 32'h0000_00AA);
    step();
    chk("idle_drvalid", 32'(drvalid), 32'd0);
    chk("idle_drdata_hold", drdata, 32'h0000_00AA);
    chk("idle_raddr_hold", 32'(mem_raddr), 32'd7);

    // Reset in the cycle after a fetch grant.
    ireq = 1'b1; iaddr = 9'd1;
    #1;
    chk("pre_rst_ignt", 32'(ignt), 32'd1);
    step();
    ireq = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    ireq = 1'b1; dreq = 1'b1; dwe = 1'b0; daddr = 9'd5;
    #1;
    chk("mid_rst_irvalid", 32'(irvalid), 32'd0);
    chk("mid_rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("mid_rst_ignt", 32'(ignt), 32'd0);
    chk("mid_rst_dgnt", 32'(dgnt), 32'd0);
    chk("mid_rst_host_gnt", 32'(host_gnt), 32'd0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    step();
    chk("mid_rst_drvalid", 32'(drvalid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

endmodule
